// File: rtl/stage_mem_lsu.sv
// ---------------------------------------------------------------------------
// stage_mem_lsu
//
// Memory stage of the RV32 pipeline. Takes the ALU result as the effective
// address and register B as store data, runs one load or store per
// instruction over a request/acknowledge bus, and stalls the upstream stages
// until the access finishes. Load data is aligned and sign/zero-extended
// for writeback. Misaligned, illegal and timed-out accesses raise o_fault.
//
// Ports:
//   i_clock, i_reset        rising-edge clock, synchronous active-high reset
//   i_valid                 instruction present from execute
//   i_memRd, i_memWr        load / store request
//   i_size                  00 byte, 01 half, 10 word, 11 illegal
//   i_unsigned              zero-extend loads (LBU/LHU)
//   i_address, i_dataB      effective address, store data
//   o_busAddr               word-aligned bus address
//   o_busRdEnable           bus read strobe
//   o_busWrEnable           bus write strobe
//   o_busByteEnable         active byte lanes
//   o_busWrData             lane-replicated store data
//   i_busRdData, i_busAck   bus read data and completion
//   o_busy                  stall request to upstream stages
//   o_done                  one-cycle pulse, access completed
//   o_rdData                extended load data, valid with o_done
//   o_fault                 one-cycle pulse, illegal or timed-out access
// ---------------------------------------------------------------------------
module stage_mem_lsu #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_valid,
   input  logic                    i_memRd,
   input  logic                    i_memWr,
   input  logic [1:0]              i_size,
   input  logic                    i_unsigned,
   input  logic [DATA_WIDTH-1:0]   i_address,
   input  logic [DATA_WIDTH-1:0]   i_dataB,
   output logic [DATA_WIDTH-1:0]   o_busAddr,
   output logic                    o_busRdEnable,
   output logic                    o_busWrEnable,
   output logic [3:0]              o_busByteEnable,
   output logic [DATA_WIDTH-1:0]   o_busWrData,
   input  logic [DATA_WIDTH-1:0]   i_busRdData,
   input  logic                    i_busAck,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [DATA_WIDTH-1:0]   o_rdData,
   output logic                    o_fault
);

   // The lane logic below is written for a 32-bit bus only.
   if (DATA_WIDTH != 32) begin : gBadWidth
      $error("stage_mem_lsu: DATA_WIDTH must be 32");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Value of the counter on the last REQ cycle allowed without an ack.
   localparam logic [31:0] TimeoutLast =
      (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
   localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);

   state_t       state_q, state_d;
   logic [31:0]  timeoutCnt_q, timeoutCnt_d;
   logic         timedOut_q, timedOut_d;
   logic [31:0]  busAddr_q;
   logic [3:0]   byteEn_q;
   logic [31:0]  wrData_q;
   logic         isWrite_q;
   logic [1:0]   size_q;
   logic         unsigned_q;
   logic [1:0]   byteOff_q;
   logic [31:0]  rdData_q;

   logic         start;
   logic         illegal;
   logic         accept;
   logic         capture;
   logic [3:0]   byteEnNext;
   logic [31:0]  wrDataNext;
   logic [31:0]  loadShifted;
   logic [31:0]  loadExt;

   assign start = i_valid & (i_memRd | i_memWr);

   // Conflicting direction, reserved size, or an address not naturally
   // aligned for the requested size.
   assign illegal = (i_memRd & i_memWr)
                  | (i_size == 2'b11)
                  | ((i_size == 2'b01) & i_address[0])
                  | ((i_size == 2'b10) & (i_address[1:0] != 2'b00));

   // Byte lanes and replicated store data for the incoming instruction,
   // latched only when the access is accepted.
   always_comb begin
      byteEnNext = 4'b1111;
      wrDataNext = i_dataB;
      case (i_size)
         2'b00: begin
            byteEnNext = 4'b0001 << i_address[1:0];
            wrDataNext = {4{i_dataB[7:0]}};
         end
         2'b01: begin
            byteEnNext = 4'b0011 << {i_address[1], 1'b0};
            wrDataNext = {2{i_dataB[15:0]}};
         end
         default: begin
            byteEnNext = 4'b1111;
            wrDataNext = i_dataB;
         end
      endcase
   end

   // Bring the addressed byte/half down to bit 0, then extend from the
   // top bit of the access unless the unsigned flag is set.
   assign loadShifted = i_busRdData >> {byteOff_q, 3'b000};

   always_comb begin
      loadExt = loadShifted;
      case (size_q)
         2'b00:   loadExt = unsigned_q ? {24'd0, loadShifted[7:0]}
                                       : {{24{loadShifted[7]}}, loadShifted[7:0]};
         2'b01:   loadExt = unsigned_q ? {16'd0, loadShifted[15:0]}
                                       : {{16{loadShifted[15]}}, loadShifted[15:0]};
         default: loadExt = loadShifted;
      endcase
   end

   // Control FSM: next state, stall/handshake outputs and datapath enables.
   // Illegal starts fault immediately and never leave IDLE; DONE always
   // returns to IDLE so the instruction still on the inputs is not re-run.
   always_comb begin
      state_d       = state_q;
      timeoutCnt_d  = timeoutCnt_q;
      timedOut_d    = timedOut_q;
      accept        = 1'b0;
      capture       = 1'b0;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      o_fault       = 1'b0;
      o_busRdEnable = 1'b0;
      o_busWrEnable = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (illegal) begin
                  o_fault = 1'b1;
               end else begin
                  o_busy       = 1'b1;
                  accept       = 1'b1;
                  timeoutCnt_d = 32'd0;
                  timedOut_d   = 1'b0;
                  state_d      = REQ;
               end
            end
         end
         REQ: begin
            o_busy        = 1'b1;
            o_busRdEnable = ~isWrite_q;
            o_busWrEnable = isWrite_q;
            if (i_busAck) begin
               capture = ~isWrite_q;
               state_d = DONE;
            end else begin
               timeoutCnt_d = timeoutCnt_q + 32'd1;
               if (TimeoutEn && (timeoutCnt_q == TimeoutLast)) begin
                  timedOut_d = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            o_done  = ~timedOut_q;
            o_fault = timedOut_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, timeout tracking and the latched access/result registers.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= IDLE;
         timeoutCnt_q <= 32'd0;
         timedOut_q   <= 1'b0;
         busAddr_q    <= 32'd0;
         byteEn_q     <= 4'd0;
         wrData_q     <= 32'd0;
         isWrite_q    <= 1'b0;
         size_q       <= 2'd0;
         unsigned_q   <= 1'b0;
         byteOff_q    <= 2'd0;
         rdData_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         timeoutCnt_q <= timeoutCnt_d;
         timedOut_q   <= timedOut_d;
         if (accept) begin
            busAddr_q  <= {i_address[31:2], 2'b00};
            byteEn_q   <= byteEnNext;
            wrData_q   <= wrDataNext;
            isWrite_q  <= i_memWr;
            size_q     <= i_size;
            unsigned_q <= i_unsigned;
            byteOff_q  <= i_address[1:0];
         end
         if (capture) begin
            rdData_q <= loadExt;
         end
      end
   end

   assign o_busAddr       = busAddr_q;
   assign o_busByteEnable = byteEn_q;
   assign o_busWrData     = wrData_q;
   assign o_rdData        = rdData_q;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_stage_mem_lsu
//
// Directed bench for stage_mem_lsu, built with a 4-cycle timeout so the
// abort path is reachable quickly. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_stage_mem_lsu;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        i_memRd;
   logic        i_memWr;
   logic [1:0]  i_size;
   logic        i_unsigned;
   logic [31:0] i_address;
   logic [31:0] i_dataB;
   logic [31:0] o_busAddr;
   logic        o_busRdEnable;
   logic        o_busWrEnable;
   logic [3:0]  o_busByteEnable;
   logic [31:0] o_busWrData;
   logic [31:0] i_busRdData;
   logic        i_busAck;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_rdData;
   logic        o_fault;

   int checks = 0;
   int errors = 0;

   stage_mem_lsu #(
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_valid         (i_valid),
      .i_memRd         (i_memRd),
      .i_memWr         (i_memWr),
      .i_size          (i_size),
      .i_unsigned      (i_unsigned),
      .i_address       (i_address),
      .i_dataB         (i_dataB),
      .o_busAddr       (o_busAddr),
      .o_busRdEnable   (o_busRdEnable),
      .o_busWrEnable   (o_busWrEnable),
      .o_busByteEnable (o_busByteEnable),
      .o_busWrData     (o_busWrData),
      .i_busRdData     (i_busRdData),
      .i_busAck        (i_busAck),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_rdData        (o_rdData),
      .o_fault         (o_fault)
   );

   // 10 ns clock.
   always #5 i_clock = ~i_clock;

   // Presents one instruction to the stage.
   task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] dataB);
      i_valid    = valid;
      i_memRd    = rd;
      i_memWr    = wr;
      i_size     = size;
      i_unsigned = uns;
      i_address  = addr;
      i_dataB    = dataB;
   endtask

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Advance to 1 ns after the next rising edge (input drive point).
   task automatic nextCycle();
      @(posedge i_clock);
      #1;
   endtask

   // Advance to the falling edge of the current cycle (sample point).
   task automatic sample();
      @(negedge i_clock);
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_reset     = 1'b1;
      i_busAck    = 1'b0;
      i_busRdData = 32'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      nextCycle();
      nextCycle();
      sample();
      checkOutput("reset busy",     32'(o_busy), 32'd0);
      checkOutput("reset done",     32'(o_done), 32'd0);
      checkOutput("reset fault",    32'(o_fault), 32'd0);
      checkOutput("reset rdEn",     32'(o_busRdEnable), 32'd0);
      checkOutput("reset wrEn",     32'(o_busWrEnable), 32'd0);
      checkOutput("reset BE",       32'(o_busByteEnable), 32'd0);
      checkOutput("reset busAddr",  o_busAddr, 32'd0);
      checkOutput("reset wrData",   o_busWrData, 32'd0);
      checkOutput("reset rdData",   o_rdData, 32'd0);
      nextCycle();
      i_reset = 1'b0;

      // LW 0x100, ack on the first REQ cycle.
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
      sample();
      checkOutput("lw T busy",      32'(o_busy), 32'd1);
      checkOutput("lw T rdEn",      32'(o_busRdEnable), 32'd0);
      nextCycle();
      i_busAck    = 1'b1;
      i_busRdData = 32'hDEAD_BEEF;
      sample();
      checkOutput("lw REQ busy",    32'(o_busy), 32'd1);
      checkOutput("lw REQ rdEn",    32'(o_busRdEnable), 32'd1);
      checkOutput("lw REQ wrEn",    32'(o_busWrEnable), 32'd0);
      checkOutput("lw REQ busAddr", o_busAddr, 32'h0000_0100);
      checkOutput("lw REQ BE",      32'(o_busByteEnable), 32'hF);
      nextCycle();
      i_busAck = 1'b0;
      sample();
      checkOutput("lw DONE done",   32'(o_done), 32'd1);
      checkOutput("lw DONE rdData", o_rdData, 32'hDEAD_BEEF);
      checkOutput("lw DONE busy",   32'(o_busy), 32'd0);
      checkOutput("lw DONE rdEn",   32'(o_busRdEnable), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      sample();
      checkOutput("lw after done",  32'(o_done), 32'd0);
      checkOutput("lw after busy",  32'(o_busy), 32'd0);

      // LB 0x203, signed.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      i_busAck    = 1'b1;
      i_busRdData = 32'h80FF_0000;
      sample();
      checkOutput("lb REQ BE",      32'(o_busByteEnable), 32'h8);
      checkOutput("lb REQ busAddr", o_busAddr, 32'h0000_0200);
      nextCycle();
      i_busAck = 1'b0;
      sample();
      checkOutput("lb DONE done",   32'(o_done), 32'd1);
      checkOutput("lb DONE rdData", o_rdData, 32'hFFFF_FF80);

      // LBU 0x203.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      i_busAck = 1'b1;
      nextCycle();
      i_busAck = 1'b0;
      sample();
      checkOutput("lbu DONE done",   32'(o_done), 32'd1);
      checkOutput("lbu DONE rdData", o_rdData, 32'h0000_0080);

      // SH 0x402, ack after 3 wait cycles.
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'h1234_ABCD);
      sample();
      checkOutput("sh T busy",      32'(o_busy), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
         i_busAck = (k == 4);
         sample();
         checkOutput($sformatf("sh REQ%0d wrEn", k),    32'(o_busWrEnable), 32'd1);
         checkOutput($sformatf("sh REQ%0d rdEn", k),    32'(o_busRdEnable), 32'd0);
         checkOutput($sformatf("sh REQ%0d wrData", k),  o_busWrData, 32'hABCD_ABCD);
         checkOutput($sformatf("sh REQ%0d BE", k),      32'(o_busByteEnable), 32'hC);
         checkOutput($sformatf("sh REQ%0d busAddr", k), o_busAddr, 32'h0000_0400);
         checkOutput($sformatf("sh REQ%0d done", k),    32'(o_done), 32'd0);
      end
      nextCycle();
      i_busAck = 1'b0;
      sample();
      checkOutput("sh DONE done",   32'(o_done), 32'd1);
      checkOutput("sh DONE wrEn",   32'(o_busWrEnable), 32'd0);
      checkOutput("sh DONE rdData", o_rdData, 32'h0000_0080);

      // Illegal starts: misaligned LW, size 11, rd and wr together.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0);
      sample();
      checkOutput("mis fault",      32'(o_fault), 32'd1);
      checkOutput("mis busy",       32'(o_busy), 32'd0);
      checkOutput("mis rdEn",       32'(o_busRdEnable), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'd0);
      sample();
      checkOutput("mis stays idle", 32'(o_busRdEnable), 32'd0);
      checkOutput("sz11 fault",     32'(o_fault), 32'd1);
      checkOutput("sz11 busy",      32'(o_busy), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
      sample();
      checkOutput("rdwr fault",     32'(o_fault), 32'd1);
      checkOutput("rdwr busy",      32'(o_busy), 32'd0);
      nextCycle();
      // Pass-through: valid with neither direction.
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
      sample();
      checkOutput("rdwr no strobe", 32'(o_busWrEnable | o_busRdEnable), 32'd0);
      checkOutput("pass busy",      32'(o_busy), 32'd0);
      checkOutput("pass fault",     32'(o_fault), 32'd0);

      // LW with no ack: 4 REQ cycles, then timeout fault.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
         sample();
         checkOutput($sformatf("to REQ%0d rdEn", k), 32'(o_busRdEnable), 32'd1);
      end
      nextCycle();
      sample();
      checkOutput("to DONE fault",  32'(o_fault), 32'd1);
      checkOutput("to DONE done",   32'(o_done), 32'd0);
      checkOutput("to DONE rdEn",   32'(o_busRdEnable), 32'd0);
      nextCycle();
      sample();
      checkOutput("to idle fault",  32'(o_fault), 32'd0);

      // Reset on the second REQ cycle, then a late ack.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      nextCycle();
      i_reset = 1'b1;
      sample();
      checkOutput("rst REQ2 rdEn",  32'(o_busRdEnable), 32'd1);
      nextCycle();
      i_reset  = 1'b0;
      i_busAck = 1'b1;
      sample();
      checkOutput("rst rdEn",       32'(o_busRdEnable), 32'd0);
      checkOutput("rst busy",       32'(o_busy), 32'd0);
      checkOutput("rst done",       32'(o_done), 32'd0);
      checkOutput("rst fault",      32'(o_fault), 32'd0);
      nextCycle();
      i_busAck = 1'b0;
      sample();
      checkOutput("late ack done",  32'(o_done), 32'd0);
      checkOutput("late ack fault", 32'(o_fault), 32'd0);

      // SB at 0x0 completes normally.
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_00A5);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      i_busAck = 1'b1;
      sample();
      checkOutput("sb REQ BE",      32'(o_busByteEnable), 32'h1);
      checkOutput("sb REQ wrData",  o_busWrData, 32'hA5A5_A5A5);
      checkOutput("sb REQ wrEn",    32'(o_busWrEnable), 32'd1);
      nextCycle();
      i_busAck = 1'b0;
      sample();
      checkOutput("sb DONE done",   32'(o_done), 32'd1);
      checkOutput("sb DONE fault",  32'(o_fault), 32'd0);

      nextCycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
